// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_pkg
//  Purpose  : Shared types and constants for the two-requester RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

  // Owner of the RAM port for the current cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } owner_e;

  // RAM access size encodings
  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b11;

  // True for byte and half-word accesses
  function automatic logic is_subword(input logic [1:0] mask);
    return (mask == MASK_BYTE) || (mask == MASK_HALF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : One requester port of the RAM arbiter (request, beat data,
//             grant and registered read return).
//  Revision : 1.0  initial release
// ============================================================================
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mask;
  logic        signed_ext;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;

  // Requester side
  modport master (
    output req, we, addr, wdata, mask, signed_ext,
    input  gnt, rdata, rvalid
  );

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata, mask, signed_ext,
    output gnt, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_sat_counter
//  Purpose  : Saturating up-counter with synchronous clear; clear wins over
//             increment.  sat_o flags that the count has reached MAX.
//  Revision : 1.0  initial release
// ============================================================================
module arb_sat_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc_i,
  input  wire logic             clr_i,
  output logic      [WIDTH-1:0] cnt_o,
  output logic                  sat_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             w_sat;

  assign w_sat = (cnt_q == WIDTH'(MAX));

  // Next count: clear, else increment until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !w_sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = w_sat;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Arbitrates the single RAM port between the CPU (priority) and
//             the debug/loader port.  Debug gets bounded bursts while the CPU
//             waits, and pre-empts the CPU once it has waited STARVE_LIMIT.
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DBG_MAX_BURST = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ram_arbiter_if.slave     cpu_if,
  ram_arbiter_if.slave     dbg_if,
  output logic             ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  output logic [1:0]       ram_mask_o,
  output logic             ram_signed_ext_o,
  input  wire logic [31:0] ram_rdata_i
);

  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_BURST_W  = $clog2(DBG_MAX_BURST + 1);

  owner_e owner_q;
  owner_e owner_d;

  logic                  w_cpu_gnt;
  logic                  w_dbg_gnt;
  logic                  w_starving;
  logic [c_STARVE_W-1:0] w_unused_starve_cnt;
  logic                  w_unused_burst_sat;
  logic [c_BURST_W-1:0]  w_burst_cnt;
  logic [c_BURST_W:0]    w_burst_sum;
  logic                  w_burst_done;
  logic                  w_unused_dbg;

  logic        cpu_rvalid_q;
  logic [31:0] cpu_rdata_q;
  logic        dbg_rvalid_q;
  logic [31:0] dbg_rdata_q;

  // Debug accesses are always word/unsigned, so its size controls are ignored
  assign w_unused_dbg = ^{dbg_if.mask, dbg_if.signed_ext};

  // Debug wait time: counts ungranted request cycles, resets on grant or idle
  arb_sat_counter #(
    .MAX   (STARVE_LIMIT),
    .WIDTH (c_STARVE_W)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (dbg_if.req & ~w_dbg_gnt),
    .clr_i (~dbg_if.req | w_dbg_gnt),
    .cnt_o (w_unused_starve_cnt),
    .sat_o (w_starving)
  );

  // Debug beats in the current ownership period
  arb_sat_counter #(
    .MAX   (DBG_MAX_BURST),
    .WIDTH (c_BURST_W)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_dbg_gnt),
    .clr_i (owner_q != DBG),
    .cnt_o (w_burst_cnt),
    .sat_o (w_unused_burst_sat)
  );

  // Include the beat happening now so the handover lands right after it
  assign w_burst_sum  = {1'b0, w_burst_cnt} + {{c_BURST_W{1'b0}}, w_dbg_gnt};
  assign w_burst_done = (w_burst_sum >= (c_BURST_W + 1)'(DBG_MAX_BURST));

  // Owner state register
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner next-state: CPU first unless debug is starving; bounded debug bursts
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      IDLE, CPU: begin
        if (dbg_if.req && w_starving) begin
          owner_d = DBG;
        end else if (cpu_if.req) begin
          owner_d = CPU;
        end else if (dbg_if.req) begin
          owner_d = DBG;
        end else begin
          owner_d = IDLE;
        end
      end
      DBG: begin
        if (cpu_if.req && w_burst_done) begin
          owner_d = CPU;
        end else if (dbg_if.req) begin
          owner_d = DBG;
        end else if (cpu_if.req) begin
          owner_d = CPU;
        end else begin
          owner_d = IDLE;
        end
      end
      default: owner_d = IDLE;
    endcase
  end

  // Grants and RAM mux; writes are suppressed during reset
  always_comb begin
    w_cpu_gnt        = 1'b0;
    w_dbg_gnt        = 1'b0;
    ram_we_o         = 1'b0;
    ram_addr_o       = '0;
    ram_wdata_o      = '0;
    ram_mask_o       = MASK_WORD;
    ram_signed_ext_o = 1'b0;
    if ((owner_q == CPU) && cpu_if.req) begin
      w_cpu_gnt        = 1'b1;
      ram_we_o         = cpu_if.we & ~reset;
      ram_addr_o       = cpu_if.addr;
      ram_wdata_o      = cpu_if.wdata;
      ram_mask_o       = cpu_if.mask;
      ram_signed_ext_o = cpu_if.signed_ext;
    end else if ((owner_q == DBG) && dbg_if.req) begin
      w_dbg_gnt        = 1'b1;
      ram_we_o         = dbg_if.we & ~reset;
      ram_addr_o       = dbg_if.addr;
      ram_wdata_o      = dbg_if.wdata;
    end
  end

  // Read return: capture RAM data on a read beat of the granted port
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= w_cpu_gnt & ~cpu_if.we;
      dbg_rvalid_q <= w_dbg_gnt & ~dbg_if.we;
      if (w_cpu_gnt && !cpu_if.we) begin
        cpu_rdata_q <= ram_rdata_i;
      end
      if (w_dbg_gnt && !dbg_if.we) begin
        dbg_rdata_q <= ram_rdata_i;
      end
    end
  end

  assign cpu_if.gnt    = w_cpu_gnt;
  assign cpu_if.rdata  = cpu_rdata_q;
  assign cpu_if.rvalid = cpu_rvalid_q;
  assign dbg_if.gnt    = w_dbg_gnt;
  assign dbg_if.rdata  = dbg_rdata_q;
  assign dbg_if.rvalid = dbg_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed scoreboard bench for ram_arbiter with a behavioural RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_mask;
  logic        ram_signed_ext;
  logic [31:0] ram_rdata;

  ram_arbiter_if cpu_if();
  ram_arbiter_if dbg_if();

  ram_arbiter #(
    .DBG_MAX_BURST (4),
    .STARVE_LIMIT  (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_if           (cpu_if),
    .dbg_if           (dbg_if),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_wdata_o      (ram_wdata),
    .ram_mask_o       (ram_mask),
    .ram_signed_ext_o (ram_signed_ext),
    .ram_rdata_i      (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on the edge; preload port for setup
  logic [31:0] ram_mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  assign ram_rdata = ram_mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
    else if (pre_we) ram_mem[pre_idx] <= pre_data;
  end

  logic [31:0] exp_mem [0:255];
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid pops the oldest expected read of that port
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_if.rvalid) begin
        if (cpu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cpu_unexpected_rvalid: got %h expected none", cpu_if.rdata);
        end else chk("cpu_rdata", cpu_if.rdata, cpu_q.pop_front());
      end
      if (dbg_if.rvalid) begin
        if (dbg_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dbg_unexpected_rvalid: got %h expected none", dbg_if.rdata);
        end else chk("dbg_rdata", dbg_if.rdata, dbg_q.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mask, input logic sext);
    cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr;
    cpu_if.wdata = wdata; cpu_if.mask = mask; cpu_if.signed_ext = sext;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    dbg_if.req = req; dbg_if.we = we; dbg_if.addr = addr;
    dbg_if.wdata = wdata; dbg_if.mask = MASK_WORD; dbg_if.signed_ext = 1'b0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data; exp_mem[idx] = data;
    nxt();
    pre_we = 1'b0;
  endtask

  // Wait (bounded) for a grant on one port, then step past that cycle
  task automatic wait_gnt(input bit is_dbg, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (is_dbg ? dbg_if.gnt : cpu_if.gnt) begin got = 1'b1; break; end
      nxt();
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no gnt expected gnt within 40 cycles", name);
    end else nxt();
  endtask

  task automatic dbg_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dbg_drive(1'b1, we, addr, wdata);
    if (we) exp_mem[addr[9:2]] = wdata;
    else dbg_q.push_back(exp_mem[addr[9:2]]);
    wait_gnt(1'b1, "dbg_beat");
  endtask

  task automatic cpu_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_drive(1'b1, we, addr, wdata, MASK_WORD, 1'b0);
    if (we) exp_mem[addr[9:2]] = wdata;
    else cpu_q.push_back(exp_mem[addr[9:2]]);
    wait_gnt(1'b0, "cpu_beat");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_gnt"},    {31'd0, cpu_if.gnt},    32'd0);
    chk({tag, "_dbg_gnt"},    {31'd0, dbg_if.gnt},    32'd0);
    chk({tag, "_cpu_rvalid"}, {31'd0, cpu_if.rvalid}, 32'd0);
    chk({tag, "_dbg_rvalid"}, {31'd0, dbg_if.rvalid}, 32'd0);
    chk({tag, "_cpu_rdata"},  cpu_if.rdata,           32'd0);
    chk({tag, "_dbg_rdata"},  dbg_if.rdata,           32'd0);
    chk({tag, "_ram_we"},     {31'd0, ram_we},        32'd0);
    chk({tag, "_ram_addr"},   ram_addr,               32'd0);
    chk({tag, "_ram_mask"},   {30'd0, ram_mask},      {30'd0, MASK_WORD});
  endtask

  initial begin
    #100000;
    $display("watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bi;
    int dbg_before_cpu;
    bit seen_cpu, cpu_done, g_d, g_c;

    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    nxt();
    preload(8'd64, 32'hDEADBEEF);   // 0x100
    preload(8'd65, 32'h11112222);   // 0x104
    preload(8'd66, 32'h33334444);   // 0x108
    preload(8'd16, 32'h12345678);   // 0x40
    @(negedge clk);
    chk_reset_outputs("por");
    nxt();
    reset = 1'b0;
    nxt();

    // CPU read from idle: gnt at T+1, rvalid at T+2
    cpu_drive(1'b1, 1'b0, 32'h100, 32'd0, MASK_WORD, 1'b0);
    cpu_q.push_back(exp_mem[64]);
    @(negedge clk); chk("t1_gnt_T", {31'd0, cpu_if.gnt}, 32'd0);
    nxt();
    @(negedge clk); chk("t1_gnt_T1", {31'd0, cpu_if.gnt}, 32'd1);
    chk("t1_ram_addr", ram_addr, 32'h100);
    nxt(); cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    @(negedge clk); chk("t1_rvalid_T2", {31'd0, cpu_if.rvalid}, 32'd1);
    nxt(); nxt();

    // Simultaneous requests: CPU first, debug after CPU drops
    cpu_drive(1'b1, 1'b0, 32'h100, 32'd0, MASK_WORD, 1'b0);
    cpu_q.push_back(exp_mem[64]);
    dbg_drive(1'b1, 1'b0, 32'h104, 32'd0);
    dbg_q.push_back(exp_mem[65]);
    @(negedge clk);
    chk("t2_T_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd0);
    chk("t2_T_dbg_gnt", {31'd0, dbg_if.gnt}, 32'd0);
    nxt();
    @(negedge clk);
    chk("t2_T1_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd1);
    chk("t2_T1_dbg_gnt", {31'd0, dbg_if.gnt}, 32'd0);
    nxt();
    cpu_drive(1'b1, 1'b0, 32'h108, 32'd0, MASK_WORD, 1'b0);
    cpu_q.push_back(exp_mem[66]);
    @(negedge clk); chk("t2_T2_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd1);
    nxt(); cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    @(negedge clk);
    chk("t2_T3_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd0);
    chk("t2_T3_dbg_gnt", {31'd0, dbg_if.gnt}, 32'd0);
    nxt();
    @(negedge clk);
    chk("t2_T4_dbg_gnt", {31'd0, dbg_if.gnt}, 32'd1);
    chk("t2_T4_ram_addr", ram_addr, 32'h104);
    nxt(); dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    nxt(); nxt();

    // Starvation: CPU streams writes, debug pre-empts after 8 waiting cycles
    cpu_drive(1'b1, 1'b1, 32'h200, 32'hCAFE0001, MASK_WORD, 1'b0);
    exp_mem[128] = 32'hCAFE0001;
    dbg_drive(1'b1, 1'b0, 32'h108, 32'd0);
    dbg_q.push_back(exp_mem[66]);
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (dbg_if.gnt) begin lat = k; break; end
      nxt();
    end
    chk("t3_starve_latency", lat, 32'd9);
    nxt(); dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t3_drop_dbg_gnt", {31'd0, dbg_if.gnt}, 32'd0);
    chk("t3_drop_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd0);
    nxt();
    @(negedge clk); chk("t3_cpu_regain", {31'd0, cpu_if.gnt}, 32'd1);
    nxt(); cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    nxt(); nxt();

    // Burst limit: 10 debug writes, CPU arrives after the first beat
    for (int i = 0; i < 10; i++) exp_mem[i] = 32'(i * 4);
    exp_mem[192] = 32'hA5A50300;
    bi = 0; dbg_before_cpu = 0; seen_cpu = 1'b0; cpu_done = 1'b0;
    dbg_drive(1'b1, 1'b1, 32'd0, 32'd0);
    for (int c = 0; c < 60 && (bi < 10 || !cpu_done); c++) begin
      @(negedge clk);
      g_d = dbg_if.gnt; g_c = cpu_if.gnt;
      if (g_d && !seen_cpu) dbg_before_cpu++;
      if (g_c) seen_cpu = 1'b1;
      nxt();
      if (g_d) begin
        bi++;
        if (bi < 10) dbg_drive(1'b1, 1'b1, 32'(bi * 4), 32'(bi * 4));
        else dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (g_c) begin
        cpu_done = 1'b1;
        cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
      end else if (!cpu_done && bi >= 1) begin
        cpu_drive(1'b1, 1'b1, 32'h300, 32'hA5A50300, MASK_WORD, 1'b0);
      end
    end
    chk("t4_dbg_beats_before_cpu", dbg_before_cpu, 32'd4);
    chk("t4_dbg_beats_total", bi, 32'd10);
    chk("t4_cpu_beat_done", {31'd0, cpu_done}, 32'd1);
    for (int i = 0; i < 10; i++) dbg_beat(1'b0, 32'(i * 4), 32'd0);
    dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    cpu_beat(1'b0, 32'h300, 32'd0);
    cpu_beat(1'b0, 32'h200, 32'd0);
    cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    nxt(); nxt();

    // Reset during a debug write beat to 0x40
    dbg_drive(1'b1, 1'b1, 32'h40, 32'hBAD0BAD0);
    @(negedge clk);
    nxt();
    reset = 1'b1;
    @(negedge clk); chk("t5_ram_we_in_reset", {31'd0, ram_we}, 32'd0);
    nxt();
    reset = 1'b0;
    dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk_reset_outputs("t5");
    nxt();
    dbg_beat(1'b0, 32'h40, 32'd0);
    dbg_drive(1'b0, 1'b0, 32'd0, 32'd0);
    nxt(); nxt();

    // CPU sub-word signed load: size controls pass straight to the RAM
    cpu_drive(1'b1, 1'b0, 32'h103, 32'd0, MASK_BYTE, 1'b1);
    cpu_q.push_back(exp_mem[64]);
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("t6_cpu_gnt", {31'd0, cpu_if.gnt}, 32'd1);
    chk("t6_ram_mask", {30'd0, ram_mask}, {30'd0, MASK_BYTE});
    chk("t6_ram_sext", {31'd0, ram_signed_ext}, 32'd1);
    chk("t6_ram_addr", ram_addr, 32'h103);
    nxt(); cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, MASK_WORD, 1'b0);
    nxt(); nxt();

    chk("end_cpu_q_empty", cpu_q.size(), 32'd0);
    chk("end_dbg_q_empty", dbg_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
